// File: rtl/exe_stage.sv
// Execute stage: ALU, jump resolution against a registered zero flag, and the EXE/MEM register.
// A squash counter turns younger wrong-path instructions into bubbles after a taken jump.
module exe_stage #(
  parameter int unsigned ARQ          = 16,
  parameter int unsigned ADDR_W       = 13,
  parameter int unsigned SQUASH_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              wb_en_in,
  input  logic              rd_mem_en_in,
  input  logic              wr_mem_en_in,
  input  logic              mux_exe_in,
  input  logic              mux_mem_in,
  input  logic              jop_lsb_in,
  input  logic              jenable_in,
  input  logic              pc_en_in,
  input  logic [ARQ-1:0]    src1_in,
  input  logic [ARQ-1:0]    src2_in,
  input  logic [ARQ-1:0]    src3_in,
  input  logic [ARQ-1:0]    imm_in,
  input  logic [1:0]        alu_op_in,
  input  logic [ADDR_W-1:0] jaddr_in,
  output logic              wb_en_mem,
  output logic              rd_mem_en_mem,
  output logic              wr_mem_en_mem,
  output logic              mux_mem_mem,
  output logic              pc_en_mem,
  output logic [ARQ-1:0]    alu_result_mem,
  output logic [ARQ-1:0]    src1_mem,
  output logic [ARQ-1:0]    src3_mem,
  output logic              branch_taken,
  output logic [ADDR_W-1:0] jaddr_out,
  output logic              zero_flag
);

  logic [1:0]     squash_cnt, squash_cnt_d;
  logic           live, jump_take, flag_upd;
  logic [ARQ-1:0] alu_b, alu_result;

  always_comb begin
    live      = (squash_cnt == 2'd0);
    alu_b     = mux_exe_in ? imm_in : src2_in;
    alu_result = '0;
    unique case (alu_op_in)
      2'b00:   alu_result = src1_in + alu_b;
      2'b01:   alu_result = src1_in - alu_b;
      2'b10:   alu_result = ARQ'(src1_in * alu_b);
      default: alu_result = alu_b;
    endcase
    // Uses the flag as registered before this instruction's own update.
    jump_take = live & jenable_in & (~jop_lsb_in | zero_flag);
    flag_upd  = live & wb_en_in & ~jenable_in;
    squash_cnt_d = squash_cnt;
    if (jump_take) begin
      squash_cnt_d = 2'(SQUASH_DEPTH);
    end else if (!live) begin
      squash_cnt_d = squash_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_mem      <= 1'b0;
      rd_mem_en_mem  <= 1'b0;
      wr_mem_en_mem  <= 1'b0;
      mux_mem_mem    <= 1'b0;
      pc_en_mem      <= 1'b0;
      alu_result_mem <= '0;
      src1_mem       <= '0;
      src3_mem       <= '0;
      branch_taken   <= 1'b0;
      jaddr_out      <= '0;
      zero_flag      <= 1'b0;
      squash_cnt     <= 2'd0;
    end else if (!stall) begin
      wb_en_mem      <= live & wb_en_in & ~jenable_in;
      rd_mem_en_mem  <= live & rd_mem_en_in;
      wr_mem_en_mem  <= live & wr_mem_en_in & ~jenable_in;
      mux_mem_mem    <= mux_mem_in;
      pc_en_mem      <= pc_en_in;
      alu_result_mem <= alu_result;
      src1_mem       <= src1_in;
      src3_mem       <= src3_in;
      branch_taken   <= jump_take;
      if (jump_take) begin
        jaddr_out <= jaddr_in;
      end
      if (flag_upd) begin
        zero_flag <= (alu_result == '0);
      end
      squash_cnt     <= squash_cnt_d;
    end
  end

endmodule
